// File: rtl/mode_sequencer_if.sv
// Button-path and mode-status signals between the controller decoder and the mode sequencer.
// The master drives the raw inputs; the slave (sequencer) drives mode and gated button outputs.
interface mode_sequencer_if;
  logic [4:0] nes_in;
  logic       mode_btn;
  logic [3:0] state;
  logic [4:0] nes_out;
  logic       btn_valid;
  logic       mode_change;

  modport master (
    output nes_in,
    output mode_btn,
    input  state,
    input  nes_out,
    input  btn_valid,
    input  mode_change
  );

  modport slave (
    input  nes_in,
    input  mode_btn,
    output state,
    output nes_out,
    output btn_valid,
    output mode_change
  );
endinterface

// File: rtl/mode_sequencer.sv
// Three-mode button gate: mode_btn cycles the mode, each mode passes one window of button codes.
// Defining MODE_TIMEOUT_EN adds an idle counter that returns the device to mode 0.
module mode_sequencer #(
  parameter int unsigned LOCKOUT = 4,
  parameter int unsigned TIMEOUT = 12000000
) (
  input logic            clk,
  input logic            reset,
  mode_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    StMode0 = 4'd0,
    StMode1 = 4'd1,
    StMode2 = 4'd2
  } mode_e;

  localparam logic [4:0] NesNone  = 5'd12;
  localparam logic [7:0] LockLoad = 8'(LOCKOUT);

  if (LOCKOUT < 1 || LOCKOUT > 255) begin : g_lockout_range
    $error("mode_sequencer: LOCKOUT must be 1..255");
  end
  if (TIMEOUT < 1 || TIMEOUT > 32'h00FF_FFFF) begin : g_timeout_range
    $error("mode_sequencer: TIMEOUT must be 1..2^24-1");
  end

  logic       sync1_q, sync2_q, btn_prev_q;
  logic [1:0] warm_q;
  logic       btn_edge;

  mode_e      state_q;
  logic [4:0] nes_out_q;
  logic       btn_valid_q;
  logic       mode_change_q;
  logic [7:0] lock_q;

  mode_e      state_adv;
  mode_e      state_next;
  logic       in_window;
  logic       state_bad;
  logic       expire;
  logic       change;
  logic [4:0] gated;
  logic       valid_d;

  // Edges are ignored until the synchronizer and edge flop hold post-reset samples, so a
  // button held through reset release is never seen as a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      btn_prev_q <= 1'b0;
      warm_q     <= 2'd0;
    end else begin
      sync1_q    <= bus.mode_btn;
      sync2_q    <= sync1_q;
      btn_prev_q <= sync2_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  assign btn_edge = (warm_q == 2'd3) && sync2_q && !btn_prev_q;

  always_comb begin
    state_adv = StMode0;
    in_window = 1'b0;
    state_bad = 1'b0;
    case (state_q)
      StMode0: begin
        state_adv = StMode1;
        in_window = (bus.nes_in[4:2] == 3'b001);
      end
      StMode1: begin
        state_adv = StMode2;
        in_window = (bus.nes_in[4:2] == 3'b010);
      end
      StMode2: begin
        state_adv = StMode0;
        in_window = (bus.nes_in[4:2] == 3'b000);
      end
      default: state_bad = 1'b1;
    endcase
  end

  // Illegal state and timeout both land in mode 0; a button edge always takes precedence.
  assign state_next = (btn_edge && !state_bad) ? state_adv : StMode0;
  assign change     = state_bad || btn_edge || expire;
  assign gated      = in_window ? bus.nes_in : NesNone;
  // A counter of 1 is the last suppressed cycle, so the output computed now is already live.
  assign valid_d    = !change && (lock_q <= 8'd1) && (gated != NesNone) && (gated != nes_out_q);

`ifdef MODE_TIMEOUT_EN
  logic [23:0] idle_q;

  // idle_q is 0 in the first idle cycle, so TIMEOUT cycles have elapsed at TIMEOUT-1.
  assign expire = (state_q != StMode0) && (idle_q == 24'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q <= 24'd0;
    end else if (state_q == StMode0 || change || valid_d) begin
      idle_q <= 24'd0;
    end else begin
      idle_q <= idle_q + 24'd1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StMode0;
      nes_out_q     <= NesNone;
      btn_valid_q   <= 1'b0;
      mode_change_q <= 1'b0;
      lock_q        <= 8'd0;
    end else begin
      btn_valid_q   <= valid_d;
      mode_change_q <= 1'b0;
      if (change) begin
        state_q       <= state_next;
        mode_change_q <= 1'b1;
        lock_q        <= LockLoad;
        nes_out_q     <= NesNone;
      end else if (lock_q > 8'd1) begin
        lock_q    <= lock_q - 8'd1;
        nes_out_q <= NesNone;
      end else begin
        if (lock_q != 8'd0) lock_q <= lock_q - 8'd1;
        nes_out_q <= gated;
      end
    end
  end

  assign bus.state       = state_q;
  assign bus.nes_out     = nes_out_q;
  assign bus.btn_valid   = btn_valid_q;
  assign bus.mode_change = mode_change_q;

endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameter LOCKOUT, default 4: cycles after a mode change during which all button codes are suppressed; 1..255.
REQ-002 Parameter TIMEOUT, default 12000000: idle cycles before the auto-return to mode 0; 1..2^24-1.
REQ-003 Port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port nes_in  input  5  raw button code from the controller decoder: 0..11 = button, 12 = none, 13..31 = invalid.
REQ-006 Port mode_btn  input  1  asynchronous level from the mode-select button.
REQ-007 Port state  output  4  current device mode: 0, 1 or 2; drives the button-select mux.
REQ-008 Port nes_out  output  5  registered, mode-gated button code; 12 = none.
REQ-009 Port btn_valid  output  1  one-cycle pulse marking a new accepted press.
REQ-010 Port mode_change  output  1  one-cycle pulse on every change of state.

Function
REQ-011 Mode windows SHALL be: mode 0 accepts codes 4..7; mode 1 accepts 8..11; mode 2 accepts 0..3.
REQ-012 Codes outside the current window, including 12..31, SHALL produce nes_out = 12.
REQ-013 nes_out SHALL be registered, with latency of exactly 1 cycle from nes_in.
REQ-014 mode_btn SHALL pass through a 2-flop synchronizer, then a registered rising-edge detector.
REQ-015 state SHALL update at the 3rd clk edge that samples mode_btn high; a held button SHALL give exactly one advance.
REQ-016 Each detected mode_btn edge SHALL advance state in the sequence 0 -> 1 -> 2 -> 0.
REQ-017 state values 3..15 SHALL never occur; if one is reached, the next cycle SHALL force state = 0 and pulse mode_change.
REQ-018 mode_change SHALL be high during the first cycle in which the new state value is visible.
REQ-019 On each mode change, a lockout counter SHALL load LOCKOUT.
REQ-020 While the lockout counter is non-zero, nes_out SHALL be 12, btn_valid SHALL be 0, and the counter SHALL decrement once per cycle.
REQ-021 btn_valid SHALL pulse in the cycle where nes_out moves from 12 to an accepted code.
REQ-022 btn_valid SHALL also pulse when nes_out moves from one accepted code directly to a different accepted code.
REQ-023 A held code SHALL NOT repeat btn_valid.
REQ-024 A mode_btn edge and an accepted press in the same cycle: the mode change SHALL win, the press SHALL be discarded and lockout SHALL start.
REQ-025 A mode_btn edge and timeout expiry in the same cycle: the mode_btn advance SHALL win and the idle counter SHALL clear.
REQ-026 nes_in changing during lockout SHALL be re-evaluated on the first cycle after lockout ends, with no latched history.

Reset
REQ-027 While reset is high: state = 0, nes_out = 12, btn_valid = 0, mode_change = 0.
REQ-028 While reset is high: synchronizer/edge flops = 0, lockout counter = 0, idle counter = 0.
REQ-029 Reset asserted mid-lockout or mid-timeout SHALL abort the operation with no pulse emitted.
REQ-030 A mode_btn held through reset release SHALL NOT cause an advance.

Configuration
REQ-031 With macro MODE_TIMEOUT_EN defined, a 24-bit idle counter SHALL increment each cycle while state != 0.
REQ-032 With MODE_TIMEOUT_EN defined, the idle counter SHALL clear on btn_valid, on mode_change or when state = 0.
REQ-033 With MODE_TIMEOUT_EN defined, reaching TIMEOUT SHALL set state = 0 on the next edge, pulse mode_change and start lockout.
REQ-034 Without MODE_TIMEOUT_EN, the idle counter SHALL NOT exist and state SHALL change only on mode_btn or reset.

Verification
REQ-035 Reset, then hold nes_in = 5 -> nes_out = 5 one cycle later; btn_valid pulses once; state = 0.
REQ-036 state = 0, nes_in = 9 -> nes_out = 12 and no btn_valid; nes_in = 13 -> nes_out = 12.
REQ-037 mode_btn pulse held 10 cycles -> state 0 -> 1 at the 3rd edge; single mode_change pulse; nes_in = 9 gated for 4 cycles, then nes_out = 9 with one btn_valid.
REQ-038 Three mode_btn presses -> state 1, 2, 0; in state 2, nes_in = 2 is accepted and nes_in = 6 gives 12.
REQ-039 mode_btn edge coincident with a new nes_in = 10 in state 1 -> state = 2, no btn_valid, lockout starts.
REQ-040 MODE_TIMEOUT_EN defined, TIMEOUT = 20, state 1 idle -> state = 0 after 20 cycles with mode_change; a press at cycle 19 restarts the count.
